csr_hpm_counters: RTL
=====================

# csr_hpm_counters

Parametrised machine counter unit replacing the fixed mcycle/minstret pair in the CSR file. Holds mcycle, minstret and NUM_HPM programmable hardware performance counters, each selecting one of NUM_EVT event inputs. It also holds mcountinhibit and the per-counter event selectors. It sits beside the CSR file in the EXE stage, is accessed with the existing CSR control encoding, and returns read data one cycle later.

## Interface
- NUM_HPM, 4: programmable counters mhpmcounter3..3+NUM_HPM-1; legal range 1..29
- NUM_EVT, 8: event inputs; legal range 1..31
- CNT_WIDTH, 64: implemented counter width; legal range 33..64
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- csr_en  in  1  CSR access this cycle
- csr_we  in  1  write enable, qualified by csr_en
- csr_op_sel  in  csr_op_sel_t  NONE/ASSIGN/SET_BITS/CLR_BITS
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write operand
- inst_retired  in  1  one instruction retired this cycle
- evt  in  NUM_EVT  event strobes; evt[k] is event id k+1
- csr_rdata  out  32  read data, registered
- csr_hit  out  1  registered; previous-cycle access decoded to this block
- csr_illegal  out  1  registered; previous-cycle write targeted a read-only alias

## Operation
- Address map:
  - mcycle B00/B80 (lo/hi), minstret B02/B82, mhpmcounterN B00+N / B80+N.
  - Read-only user aliases: cycle C00/C80, instret C02/C82, hpmcounterN C00+N / C80+N.
  - mcountinhibit 320: bit0 = cycle, bit2 = instret, bitN = hpmN. All other bits are hardwired 0.
  - mhpmeventN 320+N: bits [4:0] = event id; other bits read 0.
- Increment rules:
  - mcycle: +1 every cycle unless inhibited.
  - minstret: +1 when inst_retired and not inhibited.
  - hpmN: +1 when its event id is 1..NUM_EVT, evt[id-1] is high, and the counter is not inhibited.
  - Event id 0 or >NUM_EVT never counts.
- Counter width: counters are CNT_WIDTH wide and wrap modulo 2^CNT_WIDTH. Hi-half bits above CNT_WIDTH read 0 and are dropped on write.
- Write is performed when csr_en & csr_we & op_sel!=NONE:
  - ASSIGN: new = wdata.
  - SET_BITS: new = old | wdata.
  - CLR_BITS: new = old & ~wdata.
  - A write touches only the addressed 32-bit half.
- Write to a counter half in the same cycle as an increment: the written value wins and that cycle's increment is lost. The other half keeps its old value, with no carry from the lost increment.
- Write to any C-range alias: no state change; csr_illegal=1 next cycle.
- Unmapped address: csr_hit=0, csr_rdata=0 next cycle, no state change.
- Read returns the pre-write, pre-increment value sampled in the access cycle.

## Timing
- Reset: all counters, mcountinhibit, mhpmevent and outputs go to 0. Counting resumes the first cycle after rst deasserts.
- Read latency is 1 cycle: access in cycle N gives csr_rdata/csr_hit/csr_illegal in N+1.
- A write in cycle N is visible to a read in N+1 (data seen in N+2). Increments resume from the written value in N+1.
- mcountinhibit or mhpmevent written in cycle N affects counting from N+1. Counting in cycle N uses the old settings.
- Counter carry lo→hi happens within the cycle; there is no torn 64-bit value.
- Without csr_en, outputs return to csr_hit=0, csr_illegal=0 and csr_rdata=0 the cycle after.
- rst mid-operation overrides any concurrent write or increment.

## Structure
- Shared package additions:
  - csr_addr_t entries: CSR_MCOUNTINHIBIT 320, CSR_MHPMEVENT3 323, CSR_MHPMCOUNTER3 B03, CSR_MHPMCOUNTER3H B83, CSR_CYCLE C00, CSR_CYCLEH C80, CSR_INSTRET C02, CSR_INSTRETH C82, CSR_HPMCOUNTER3 C03, CSR_HPMCOUNTER3H C83.
  - HPM_EVT_ID_W = 5.
- Reuse from the package: csr_dw_t for counter storage, csr_op_sel_t, csr_lh_t for half selection.
- Sub-module hpm_counter: one CNT_WIDTH counter with inc, inhibit, half-write port and op_sel merge. Instantiate NUM_HPM+2 times; mcycle and minstret are fixed-source instances.

## Test plan
- Reset, then 10 idle cycles; read B00 → csr_rdata 10 or 11 per read sampling, csr_hit=1. Read C02 → 0.
- ASSIGN B00 ← FFFF_FFFF and B80 ← 0, then 2 cycles; read B80 → 1. Lo wrapped to small value.
- Write 323 ← 3, pulse evt[2] 5 times, pulse evt[0] twice; read B03 → 5. Write 320 SET_BITS 8, pulse evt[2]; B03 stays 5.
- Same-cycle ASSIGN B02 ← 100 with inst_retired=1; read B02 next cycle → 100.
- ASSIGN C00 ← 5 → csr_illegal=1, mcycle unaffected. Read 7FF → csr_hit=0, rdata 0.
- CNT_WIDTH=40: ASSIGN B80 ← FFFF_FFFF; read B80 → 0000_00FF. Counter wraps to 0 after 2^40 on lo carry.

Source files
------------

// File: rtl/csr_hpm_counters_pkg.sv
// Shared CSR definitions used by the machine counter unit.
// Provides the CSR operand/operation types, the counter-related CSR addresses,
// the event selector width and two small helpers (read-modify-write merge and
// counter slot to CSR counter-number mapping).
package csr_hpm_counters_pkg;

  // Double-word storage for counters; upper bits beyond the implemented width stay 0.
  typedef logic [63:0] csr_dw_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE     = 2'd0,
    CSR_OP_ASSIGN   = 2'd1,
    CSR_OP_SET_BITS = 2'd2,
    CSR_OP_CLR_BITS = 2'd3
  } csr_op_sel_t;

  typedef enum logic {
    CSR_LO = 1'b0,
    CSR_HI = 1'b1
  } csr_lh_t;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMEVENT3    = 12'h323,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MHPMCOUNTER3  = 12'hB03,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82,
    CSR_MHPMCOUNTER3H = 12'hB83,
    CSR_CYCLE         = 12'hC00,
    CSR_INSTRET       = 12'hC02,
    CSR_HPMCOUNTER3   = 12'hC03,
    CSR_CYCLEH        = 12'hC80,
    CSR_INSTRETH      = 12'hC82,
    CSR_HPMCOUNTER3H  = 12'hC83
  } csr_addr_t;

  localparam int unsigned HPM_EVT_ID_W = 5;

  // Read-modify-write merge of a 32-bit CSR field.
  function automatic logic [31:0] csr_merge(csr_op_sel_t op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    unique case (op)
      CSR_OP_ASSIGN:   return wdata;
      CSR_OP_SET_BITS: return old_val | wdata;
      CSR_OP_CLR_BITS: return old_val & ~wdata;
      default:         return old_val;
    endcase
  endfunction

  // Counter slot k -> CSR counter number: slot 0 = mcycle (0), slot 1 = minstret (2),
  // slot k >= 2 = mhpmcounter(k+1).
  function automatic logic [4:0] cnt_num(int k);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd2;
    return 5'(k + 1);
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One CNT_WIDTH-bit machine counter with increment, inhibit and a 32-bit half-write port.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   inc          increment request this cycle
//   inhibit      suppresses the increment
//   wr_en        write the half selected by wr_half using op_sel/wdata
//   count        current value, zero-extended to 64 bits
module hpm_counter
  import csr_hpm_counters_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_en,
  input  csr_lh_t     wr_half,
  input  csr_op_sel_t op_sel,
  input  logic [31:0] wdata,
  output csr_dw_t     count
);

  localparam csr_dw_t CntMask = {64{1'b1}} >> (64 - CNT_WIDTH);

  csr_dw_t cnt_q, cnt_d;

  // A write wins over the same-cycle increment; the untouched half keeps its value.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      if (wr_half == CSR_HI) begin
        cnt_d[63:32] = csr_merge(op_sel, cnt_q[63:32], wdata);
      end else begin
        cnt_d[31:0] = csr_merge(op_sel, cnt_q[31:0], wdata);
      end
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + 64'd1;
    end
    // Drops hi-half bits above CNT_WIDTH and wraps the increment.
    cnt_d = cnt_d & CntMask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine counter unit: mcycle, minstret and NUM_HPM programmable performance counters,
// plus mcountinhibit and the mhpmevent selectors, accessed with the CSR control encoding.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   csr_en/csr_we/csr_op_sel         access, write enable and operation
//   csr_addr/csr_wdata               CSR address and write operand
//   inst_retired                     one instruction retired this cycle
//   evt[NUM_EVT]                     event strobes, evt[k] is event id k+1
//   csr_rdata/csr_hit/csr_illegal    registered response to the previous-cycle access
module csr_hpm_counters
  import csr_hpm_counters_pkg::*;
#(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned NUM_EVT   = 8,
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_en,
  input  logic               csr_we,
  input  csr_op_sel_t        csr_op_sel,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic               inst_retired,
  input  logic [NUM_EVT-1:0] evt,
  output logic [31:0]        csr_rdata,
  output logic               csr_hit,
  output logic               csr_illegal
);

  localparam int unsigned NumCnt = NUM_HPM + 2;
  // Implemented mcountinhibit bits: CY, IR and one per hpm counter.
  localparam logic [31:0] InhMask = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
  localparam logic [31:0] EvtMask = 32'((1 << HPM_EVT_ID_W) - 1);

  logic [31:0]       inhibit_q, inhibit_d;
  logic [31:0]       evt_sel_q [NUM_HPM];
  logic [31:0]       evt_sel_d [NUM_HPM];
  csr_dw_t           cnt [NumCnt];
  logic [NumCnt-1:0] cnt_inc, cnt_inh, cnt_wr;
  logic              wr_req, is_cnt, is_alias, is_evt_blk;
  logic              hit_d, illegal_d;
  logic [31:0]       rdata_d, rdata_q;
  logic              hit_q, illegal_q;
  logic [4:0]        idx;
  csr_lh_t           half;

  assign idx  = csr_addr[4:0];
  assign half = csr_lh_t'(csr_addr[7]);

  // Increment sources and inhibits use the settings held at the start of the cycle.
  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[1] = inst_retired;
    for (int i = 0; i < NUM_HPM; i++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (evt_sel_q[i] == 32'(e + 1) && evt[e]) cnt_inc[i+2] = 1'b1;
      end
    end
    for (int k = 0; k < NumCnt; k++) begin
      cnt_inh[k] = inhibit_q[cnt_num(k)];
    end
  end

  always_comb begin
    wr_req     = csr_en && csr_we && (csr_op_sel != CSR_OP_NONE);
    is_cnt     = (csr_addr & 12'hF60) == CSR_MCYCLE;
    is_alias   = (csr_addr & 12'hF60) == CSR_CYCLE;
    is_evt_blk = (csr_addr & 12'hFE0) == CSR_MCOUNTINHIBIT;
    hit_d      = 1'b0;
    illegal_d  = 1'b0;
    rdata_d    = '0;
    cnt_wr     = '0;
    inhibit_d  = inhibit_q;
    evt_sel_d  = evt_sel_q;

    for (int k = 0; k < NumCnt; k++) begin
      if ((is_cnt || is_alias) && idx == cnt_num(k)) begin
        hit_d     = 1'b1;
        rdata_d   = (half == CSR_HI) ? cnt[k][63:32] : cnt[k][31:0];
        cnt_wr[k] = is_cnt && wr_req;
        illegal_d = is_alias && wr_req;
      end
    end

    for (int i = 0; i < NUM_HPM; i++) begin
      if (is_evt_blk && idx == 5'(i + 3)) begin
        hit_d   = 1'b1;
        rdata_d = evt_sel_q[i];
        if (wr_req) evt_sel_d[i] = csr_merge(csr_op_sel, evt_sel_q[i], csr_wdata) & EvtMask;
      end
    end

    if (csr_addr == CSR_MCOUNTINHIBIT) begin
      hit_d   = 1'b1;
      rdata_d = inhibit_q;
      if (wr_req) inhibit_d = csr_merge(csr_op_sel, inhibit_q, csr_wdata) & InhMask;
    end

    if (!csr_en) begin
      hit_d     = 1'b0;
      illegal_d = 1'b0;
      rdata_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
      evt_sel_q <= '{default: '0};
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      evt_sel_q <= evt_sel_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      illegal_q <= illegal_d;
    end
  end

  for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
    hpm_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (cnt_inc[k]),
      .inhibit(cnt_inh[k]),
      .wr_en  (cnt_wr[k]),
      .wr_half(half),
      .op_sel (csr_op_sel),
      .wdata  (csr_wdata),
      .count  (cnt[k])
    );
  end

  assign csr_rdata   = rdata_q;
  assign csr_hit     = hit_q;
  assign csr_illegal = illegal_q;

endmodule
